// File: rtl/mul_unit_if.sv
// Register-bank side bundle of the multiplier: operand/request inputs and write-port outputs.
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             accumulate;
  logic             set_flags;
  logic [3:0]       Rd_in;
  logic [WIDTH-1:0] Rm_data;
  logic [WIDTH-1:0] Rs_data;
  logic [WIDTH-1:0] Rn_data;

  logic             busy;
  logic             done;
  logic             latch_reg;
  logic [3:0]       Rd_out;
  logic [WIDTH-1:0] result;
  logic             flags_we;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, accumulate, set_flags, Rd_in, Rm_data, Rs_data, Rn_data,
    input  busy, done, latch_reg, Rd_out, result, flags_we, flag_n, flag_z
  );

  modport slave (
    input  start, accumulate, set_flags, Rd_in, Rm_data, Rs_data, Rn_data,
    output busy, done, latch_reg, Rd_out, result, flags_we, flag_n, flag_z
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit with early termination once the remaining multiplier is zero.
// BITS_PER_CYCLE must be 1, 2 or 4.
module mul_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  mul_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       rd_q;
  logic             sf_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] mplier_nx;

  always_comb begin
    accept    = (state_q == IDLE) && bus.start;
    mplier_nx = mplier_q >> BITS_PER_CYCLE;
    pp        = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  // Outputs are registered one cycle behind the internal DONE state, so the
  // write pulse lands on the cycle after edge N+1 and busy covers it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      sf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= accept || (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q  <= bus.Rm_data;
            mplier_q <= bus.Rs_data;
            acc_q    <= bus.accumulate ? bus.Rn_data : '0;
            rd_q     <= bus.Rd_in;
            sf_q     <= bus.set_flags;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_q + pp;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_nx;
          if (mplier_nx == '0) state_q <= DONE;
        end
        DONE: begin
          result_q <= acc_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.latch_reg = done_q;
  assign bus.Rd_out    = rd_q;
  assign bus.result    = result_q;
  assign bus.flags_we  = done_q & sf_q;
  assign bus.flag_n    = result_q[WIDTH-1];
  assign bus.flag_z    = (result_q == '0);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, corner sequences and random ops vs. an arithmetic model.
module tb_mul_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_unit_if #(.WIDTH(W)) bus ();

  mul_unit #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        acc;
    logic        sf;
    logic [3:0]  rd;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] rn;
    logic [31:0] res;
    int          n;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_n(input logic [31:0] rs);
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (rs[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 2) / 2;
  endfunction

  function automatic logic [31:0] model_res(input logic [31:0] rm, input logic [31:0] rs,
                                            input logic [31:0] rn, input logic acc);
    logic [63:0] full;
    full = 64'(rm) * 64'(rs) + (acc ? 64'(rn) : 64'd0);
    return full[31:0];
  endfunction

  task automatic scramble_inputs();
    bus.Rm_data    = $urandom;
    bus.Rs_data    = $urandom;
    bus.Rn_data    = $urandom;
    bus.Rd_in      = 4'($urandom);
    bus.accumulate = 1'($urandom);
    bus.set_flags  = 1'($urandom);
  endtask

  task automatic run_op(input vec_t v, input bit inject);
    int got;
    bit busy_ok;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.accumulate = v.acc;
    bus.set_flags  = v.sf;
    bus.Rd_in      = v.rd;
    bus.Rm_data    = v.rm;
    bus.Rs_data    = v.rs;
    bus.Rn_data    = v.rn;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_inputs();
    got     = 0;
    busy_ok = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (inject && e == 2) bus.start = 1'b1;
      if (inject && e == 5) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        got = e;
        break;
      end
    end
    chk("done_edge", 64'(got), 64'(v.n + 1));
    chk("busy_in_run", 64'(busy_ok), 64'd1);
    if (got != 0) begin
      chk("result", bus.result, v.res);
      chk("Rd_out", bus.Rd_out, v.rd);
      chk("latch_reg", bus.latch_reg, 1'b1);
      chk("flags_we", bus.flags_we, v.sf);
      chk("flag_n", bus.flag_n, v.res[31]);
      chk("flag_z", bus.flag_z, v.res == 32'd0);
      chk("busy_done", bus.busy, 1'b1);
      @(posedge clk); #1;
      chk("done_pulse", bus.done, 1'b0);
      chk("latch_pulse", bus.latch_reg, 1'b0);
      chk("idle_after", bus.busy, 1'b0);
      chk("result_held", bus.result, v.res);
    end
  endtask

  vec_t vecs [7];

  initial begin
    vec_t v;
    bit   seen_latch;

    vecs[0] = '{acc: 1'b0, sf: 1'b0, rd: 4'd4,  rm: 32'd3,          rs: 32'd5,          rn: 32'd0,  res: 32'd15,         n: 2};
    vecs[1] = '{acc: 1'b1, sf: 1'b1, rd: 4'd2,  rm: 32'hFFFF_FFFF,  rs: 32'd2,          rn: 32'd1,  res: 32'hFFFF_FFFF,  n: 1};
    vecs[2] = '{acc: 1'b0, sf: 1'b1, rd: 4'd7,  rm: 32'h1234,       rs: 32'd0,          rn: 32'd9,  res: 32'd0,          n: 1};
    vecs[3] = '{acc: 1'b0, sf: 1'b0, rd: 4'd1,  rm: 32'd1,          rs: 32'h8000_0000,  rn: 32'd0,  res: 32'h8000_0000,  n: 16};
    vecs[4] = '{acc: 1'b0, sf: 1'b1, rd: 4'd15, rm: 32'hFFFF_FFFF,  rs: 32'hFFFF_FFFF,  rn: 32'd0,  res: 32'd1,          n: 16};
    vecs[5] = '{acc: 1'b1, sf: 1'b0, rd: 4'd9,  rm: 32'd10,         rs: 32'd3,          rn: 32'd5,  res: 32'd35,         n: 1};
    vecs[6] = '{acc: 1'b0, sf: 1'b1, rd: 4'd0,  rm: 32'd7,          rs: 32'd4,          rn: 32'd3,  res: 32'd28,         n: 2};

    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.accumulate = 1'b0;
    bus.set_flags  = 1'b0;
    bus.Rd_in      = '0;
    bus.Rm_data    = '0;
    bus.Rs_data    = '0;
    bus.Rn_data    = '0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_latch", bus.latch_reg, 1'b0);
    chk("rst_flags_we", bus.flags_we, 1'b0);
    chk("rst_Rd_out", bus.Rd_out, 4'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flag_n", bus.flag_n, 1'b0);
    chk("rst_flag_z", bus.flag_z, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b0);

    // start pulsed mid-RUN must not disturb or queue behind the current op
    run_op(vecs[3], 1'b1);

    // asynchronous reset mid-RUN
    @(negedge clk);
    bus.start   = 1'b1;
    bus.Rm_data = 32'd5;
    bus.Rs_data = 32'h8000_0000;
    bus.Rd_in   = 4'd6;
    bus.accumulate = 1'b0;
    bus.set_flags  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_Rd_out", bus.Rd_out, 4'd0);
    chk("arst_flag_z", bus.flag_z, 1'b1);
    bus.start  = 1'b1;
    seen_latch = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.latch_reg || bus.busy) seen_latch = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.latch_reg || bus.busy) seen_latch = 1'b1;
    end
    chk("arst_no_write", seen_latch, 1'b0);
    v = '{acc: 1'b0, sf: 1'b0, rd: 4'd3, rm: 32'd7, rs: 32'd6, rn: 32'd0, res: 32'd42, n: 2};
    run_op(v, 1'b0);

    for (int k = 0; k < 150; k++) begin
      v.acc = 1'($urandom);
      v.sf  = 1'($urandom);
      v.rd  = 4'($urandom);
      v.rm  = $urandom;
      v.rs  = (k % 10 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      v.rn  = $urandom;
      v.res = model_res(v.rm, v.rs, v.rn, v.acc);
      v.n   = model_n(v.rs);
      run_op(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
